vga_monitor: RTL and testbench

VGA_MONITOR -- requirements
Module: vga_monitor

---
 rtl/vga_monitor.sv | 189 ++++++++++++++++++
 tb/tb_vga_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_monitor.sv
// Video timing monitor: measures line/frame geometry, sync polarity and a pixel checksum
// per frame, publishes them at each frame start and tracks lock on stable timing.
module vga_monitor #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [9:0]  h_total,
    output logic [9:0]  h_active,
    output logic [9:0]  v_total,
    output logic [9:0]  v_active,
    output logic        hsync_pol,
    output logic        vsync_pol,
    output logic [15:0] frame_sum,
    output logic [7:0]  frame_count,
    output logic        frame_done,
    output logic        locked
);
    localparam int unsigned      ToW        = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0]   ToLast     = ToW'(TIMEOUT - 1);
    localparam logic [9:0]       CntMax     = 10'd1023;
    localparam logic [7:0]       LockTarget = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    state_e         state_q, state_d;
    logic           hb_prev_q, vb_prev_q;
    logic [9:0]     hcnt_q, hcnt_d, hact_q, hact_d;
    logic [9:0]     vcnt_q, vcnt_d, vact_q, vact_d;
    logic [9:0]     line_total_q, line_total_d, line_act_q, line_act_d;
    logic           bad_q, bad_d;
    logic [15:0]    acc_q, acc_d;
    logic           pol_h_q, pol_h_d, pol_v_q, pol_v_d;
    logic [ToW-1:0] to_q, to_d;
    logic [7:0]     match_q, match_d;
    logic           has_pub_q, has_pub_d;

    logic       ls, fs, visible, line_bad, frame_bad, timeout, timing_eq, match, publish;
    logic [9:0] pix;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CntMax) ? v : v + 10'd1;
    endfunction

    assign ls      = ~hblank & hb_prev_q;
    assign fs      = ~vblank & vb_prev_q;
    assign visible = ~hblank & ~vblank;
    assign pix     = 10'(r) + 10'(g) + 10'(b);
    assign locked  = (state_q == StLocked);

    always_comb begin
        hcnt_d       = ls ? 10'd1 : sat_inc(hcnt_q);
        hact_d       = ls ? 10'd1 : (hblank ? hact_q : sat_inc(hact_q));
        line_total_d = ls ? hcnt_q : line_total_q;
        line_act_d   = ls ? hact_q : line_act_q;
        line_bad     = ls && (hcnt_q != line_total_q);
        // A mismatch found at the LS of an FS cycle belongs to the frame being closed
        frame_bad    = bad_q | line_bad;
        bad_d        = frame_bad;
        vcnt_d       = vcnt_q;
        vact_d       = vact_q;
        if (ls) begin
            vcnt_d = sat_inc(vcnt_q);
            if (!vblank) vact_d = sat_inc(vact_q);
        end
        acc_d   = visible ? acc_q + 16'(pix) : acc_q;
        pol_h_d = visible ? ~hsync : pol_h_q;
        pol_v_d = visible ? ~vsync : pol_v_q;
        if (fs) begin
            vcnt_d = ls ? 10'd1 : 10'd0;
            vact_d = ls ? 10'd1 : 10'd0;
            bad_d  = 1'b0;
            acc_d  = visible ? 16'(pix) : 16'd0;
        end
        to_d    = ls ? '0 : to_q + 1'b1;
        timeout = !ls && (to_q == ToLast);

        timing_eq = (line_total_d == h_total) && (line_act_d == h_active) &&
                    (vcnt_q == v_total) && (vact_q == v_active);
        match     = has_pub_q && !frame_bad && timing_eq;

        state_d   = state_q;
        match_d   = match_q;
        has_pub_d = has_pub_q;
        publish   = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (fs) state_d = StMeasure;
            end
            StMeasure, StLocked: begin
                if (timeout) begin
                    state_d   = StSearch;
                    match_d   = 8'd0;
                    has_pub_d = 1'b0;
                end else if (fs) begin
                    publish   = 1'b1;
                    has_pub_d = 1'b1;
                    if (match) begin
                        match_d = (match_q == 8'hff) ? match_q : match_q + 8'd1;
                        state_d = (match_d >= LockTarget) ? StLocked : StMeasure;
                    end else begin
                        match_d = 8'd0;
                        state_d = StMeasure;
                    end
                end
            end
            default: state_d = StSearch;
        endcase

        // Idle in SEARCH with everything cleared; the FS cycle itself starts the first frame
        if (state_q == StSearch && !fs) begin
            hcnt_d       = '0;
            hact_d       = '0;
            vcnt_d       = '0;
            vact_d       = '0;
            line_total_d = '0;
            line_act_d   = '0;
            bad_d        = 1'b0;
            acc_d        = '0;
            to_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StSearch;
            hb_prev_q    <= 1'b1;
            vb_prev_q    <= 1'b1;
            hcnt_q       <= '0;
            hact_q       <= '0;
            vcnt_q       <= '0;
            vact_q       <= '0;
            line_total_q <= '0;
            line_act_q   <= '0;
            bad_q        <= 1'b0;
            acc_q        <= '0;
            pol_h_q      <= 1'b0;
            pol_v_q      <= 1'b0;
            to_q         <= '0;
            match_q      <= '0;
            has_pub_q    <= 1'b0;
            h_total      <= '0;
            h_active     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            hsync_pol    <= 1'b0;
            vsync_pol    <= 1'b0;
            frame_sum    <= '0;
            frame_count  <= '0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hb_prev_q    <= hblank;
            vb_prev_q    <= vblank;
            hcnt_q       <= hcnt_d;
            hact_q       <= hact_d;
            vcnt_q       <= vcnt_d;
            vact_q       <= vact_d;
            line_total_q <= line_total_d;
            line_act_q   <= line_act_d;
            bad_q        <= bad_d;
            acc_q        <= acc_d;
            pol_h_q      <= pol_h_d;
            pol_v_q      <= pol_v_d;
            to_q         <= to_d;
            match_q      <= match_d;
            has_pub_q    <= has_pub_d;
            frame_done   <= publish;
            if (publish) begin
                h_total     <= line_total_d;
                h_active    <= line_act_d;
                v_total     <= vcnt_q;
                v_active    <= vact_q;
                frame_sum   <= acc_q;
                hsync_pol   <= pol_h_q;
                vsync_pol   <= pol_v_q;
                frame_count <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor using a compact 24x12 raster (16x8 active) and a 4x4 raster
// for frame counter wrap.
module tb_vga_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync, vsync, hblank, vblank;
    logic [7:0]  r, g, b;
    logic [9:0]  h_total, h_active, v_total, v_active;
    logic        hsync_pol, vsync_pol;
    logic [15:0] frame_sum;
    logic [7:0]  frame_count;
    logic        frame_done, locked;

    int vectors = 0;
    int miscompares = 0;

    // raster generator controls
    int         h_tot = 24, h_act = 16, v_tot = 12, v_act = 8;
    int         gen_h = 0, gen_v = 10;
    int         fs_cnt = 0;
    int         long_fs = -1, long_v = 3;
    logic       stall = 1'b0;
    logic       pos_sync = 1'b0;
    logic [7:0] pix_val = 8'd1;
    logic [7:0] exp_cnt;

    vga_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .r           (r),
        .g           (g),
        .b           (b),
        .h_total     (h_total),
        .h_active    (h_active),
        .v_total     (v_total),
        .v_active    (v_active),
        .hsync_pol   (hsync_pol),
        .vsync_pol   (vsync_pol),
        .frame_sum   (frame_sum),
        .frame_count (frame_count),
        .frame_done  (frame_done),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    initial begin
        int  line_len;
        logic hb, vb, hs_a, vs_a;
        forever begin
            @(negedge clk);
            hb     = stall || (gen_h >= h_act);
            vb     = (gen_v >= v_act);
            hs_a   = (gen_h == h_tot - 1);
            vs_a   = (gen_v == v_tot - 1);
            hblank = hb;
            vblank = vb;
            hsync  = pos_sync ? hs_a : ~hs_a;
            vsync  = pos_sync ? vs_a : ~vs_a;
            r      = (hb || vb) ? 8'd77 : pix_val;
            g      = (hb || vb) ? 8'd77 : pix_val;
            b      = (hb || vb) ? 8'd77 : pix_val;
            if (!stall && gen_h == 0 && gen_v == 0) fs_cnt++;
            if (!stall) begin
                line_len = (fs_cnt == long_fs && gen_v == long_v) ? h_tot + 1 : h_tot;
                if (gen_h >= line_len - 1) begin
                    gen_h = 0;
                    gen_v = (gen_v >= v_tot - 1) ? 0 : gen_v + 1;
                end else begin
                    gen_h++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns #1 after the edge that consumed the next frame-start cycle
    task automatic wait_next_fs();
        int target = fs_cnt + 1;
        int n = 0;
        while (fs_cnt < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (fs_cnt < target) begin
            vectors++;
            miscompares++;
            $display("FAIL fs_wait: got %0d frame starts expected %0d", fs_cnt, target);
        end
    endtask

    task automatic check_timing(input string tag, input int ht, input int ha, input int vt,
                                input int va);
        check({tag, "_h_total"}, 32'(h_total), 32'(ht));
        check({tag, "_h_active"}, 32'(h_active), 32'(ha));
        check({tag, "_v_total"}, 32'(v_total), 32'(vt));
        check({tag, "_v_active"}, 32'(v_active), 32'(va));
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_timing("rst", 0, 0, 0, 0);
        check("rst_sum", 32'(frame_sum), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_pols", {30'd0, hsync_pol, vsync_pol}, 0);
        reset = 1'b0;

        // FS1 only leaves SEARCH; FS2 publishes the first frame
        wait_next_fs();
        check("fs1_done", 32'(frame_done), 0);
        check("fs1_count", 32'(frame_count), 0);
        wait_next_fs();
        check("fs2_done", 32'(frame_done), 1);
        check_timing("fs2", 24, 16, 12, 8);
        check("fs2_pols", {30'd0, hsync_pol, vsync_pol}, 0);
        check("fs2_sum", 32'(frame_sum), 384);
        check("fs2_count", 32'(frame_count), 1);
        check("fs2_locked", 32'(locked), 0);
        @(posedge clk);
        #1;
        check("fs2_done_pulse", 32'(frame_done), 0);
        wait_next_fs();
        check("fs3_locked", 32'(locked), 1);
        check("fs3_count", 32'(frame_count), 2);

        // positive syncs, black pixels
        pos_sync = 1'b1;
        pix_val  = 8'd0;
        wait_next_fs();
        wait_next_fs();
        check("pos_pols", {30'd0, hsync_pol, vsync_pol}, 3);
        check("black_sum", 32'(frame_sum), 0);
        check("fs5_count", 32'(frame_count), 4);

        // one 25-clock line in this frame
        long_fs = fs_cnt;
        wait_next_fs();
        check("long_locked", 32'(locked), 0);
        check("long_count", 32'(frame_count), 5);
        check("long_h_total", 32'(h_total), 24);
        wait_next_fs();
        wait_next_fs();
        check("relock", 32'(locked), 1);

        // full-scale pixels wrap the checksum
        pix_val = 8'd255;
        wait_next_fs();
        wait_next_fs();
        check("wrap_sum", 32'(frame_sum), 32384);
        check("fs10_count", 32'(frame_count), 9);
        check("fs10_locked", 32'(locked), 1);

        // freeze hblank long enough to time out
        pix_val = 8'd1;
        stall   = 1'b1;
        repeat (1100) @(posedge clk);
        #1;
        check("to_locked", 32'(locked), 0);
        check("to_sum_held", 32'(frame_sum), 32384);
        check("to_count_held", 32'(frame_count), 9);
        check("to_h_total_held", 32'(h_total), 24);
        stall = 1'b0;
        wait_next_fs();
        check("to_fs_done", 32'(frame_done), 0);
        check("to_fs_count", 32'(frame_count), 9);
        wait_next_fs();
        check("to_pub_done", 32'(frame_done), 1);
        check("to_pub_count", 32'(frame_count), 10);
        check("to_pub_sum", 32'(frame_sum), 384);

        // one-cycle reset inside the frame's blanking lines
        n = 0;
        while (gen_v != 9 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_timing("mid_rst", 0, 0, 0, 0);
        check("mid_rst_sum", 32'(frame_sum), 0);
        check("mid_rst_count", 32'(frame_count), 0);
        check("mid_rst_pols", {30'd0, hsync_pol, vsync_pol}, 0);
        wait_next_fs();
        check("post_rst_fs1_done", 32'(frame_done), 0);
        wait_next_fs();
        check("post_rst_done", 32'(frame_done), 1);
        check("post_rst_count", 32'(frame_count), 1);
        check_timing("post_rst", 24, 16, 12, 8);
        check("post_rst_sum", 32'(frame_sum), 384);
        check("post_rst_pols", {30'd0, hsync_pol, vsync_pol}, 3);

        // tiny raster to run the frame counter through its wrap
        h_tot   = 4;
        h_act   = 2;
        v_tot   = 4;
        v_act   = 2;
        exp_cnt = 8'd1;
        for (int i = 0; i < 260; i++) begin
            wait_next_fs();
            exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd255 || exp_cnt == 8'd0) check("wrap_count", 32'(frame_count),
                                                            32'(exp_cnt));
        end
        check("tiny_count", 32'(frame_count), 5);
        check_timing("tiny", 4, 2, 4, 2);
        check("tiny_sum", 32'(frame_sum), 12);
        check("tiny_locked", 32'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
